test_ctrl_block: RTL and testbench
==================================

# test_ctrl_block

Test sequencer for the memory checker. It sits between the CSR block and the transmitter and turns one CSR start command into a stream of transaction requests: address, type and count. It runs the transaction valid/ready handshake, aborts on a compare error or a CSR abort, waits for the transmitter to drain, and reports completion, error and progress back to the CSRs.

## Interface
Parameters:
- ADDR_W, 31, transaction address width (same as transmitter `trans_addr_i`)
- CNT_W, 32, transaction counter width

Ports:
- clk_i  in  1  single clock
- rst_i  in  1  reset, asynchronous, active-low
- start_stb_i  in  1  one-cycle start command from CSR
- abort_stb_i  in  1  one-cycle abort command from CSR
- test_mode_i  in  2  0 READ_ONLY, 1 WRITE_ONLY, 2 WRITE_AND_CHECK, 3 reserved (treated as READ_ONLY)
- addr_mode_i  in  1  0 running, 1 random
- trans_cnt_i  in  CNT_W  number of address slots to test
- addr_base_i  in  ADDR_W  first address
- addr_high_i  in  ADDR_W  last legal address, inclusive
- addr_step_i  in  ADDR_W  running-mode increment
- addr_mask_i  in  ADDR_W  random-mode offset mask
- trans_valid_o  out  1  request valid
- trans_addr_o  out  ADDR_W  request address
- trans_type_o  out  1  0 write, 1 read
- trans_ready_i  in  1  transmitter accepts the request
- trans_busy_i  in  1  transmitter still has work stored or in flight
- cmp_error_i  in  1  compare mismatch strobe
- test_busy_o  out  1  FSM is not in IDLE
- test_done_o  out  1  one-cycle end-of-test pulse
- test_error_o  out  1  sticky error flag, cleared by the next start
- done_cnt_o  out  CNT_W  accepted handshakes, saturating

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE:**
  - On `start_stb_i`: latch all CSR inputs, load `slot_cnt = trans_cnt_i`, set `addr = addr_base_i`, clear `test_error_o` and `done_cnt_o`.
  - Next state is ISSUE, or DONE if `trans_cnt_i == 0`.
  - `start_stb_i` is ignored in every other state.
- **ISSUE:**
  - `trans_valid_o = 1`.
  - A handshake is `trans_valid_o && trans_ready_i`. On each handshake `done_cnt_o` increments, saturating at all-ones.
  - READ_ONLY: type 1 each slot.
  - WRITE_ONLY: type 0 each slot.
  - WRITE_AND_CHECK: each slot is a write followed by a read to the same address. The address advances and `slot_cnt` decrements only after the read.
  - When the handshake that completes the last slot occurs, go to DRAIN.
- **Running address:**
  - next = `addr + addr_step_i`, computed in ADDR_W+1 bits.
  - If the result is greater than `addr_high_i` (carry included), the next address is `addr_base_i`.
- **Random address:** see Configuration.
- **Abort:** `abort_stb_i` or `cmp_error_i` in ISSUE forces DRAIN after the current cycle. A handshake in that same cycle still counts.
- `cmp_error_i` in ISSUE, DRAIN or DONE sets `test_error_o`. It is ignored in IDLE.
- **DRAIN:** `trans_valid_o = 0`. Go to DONE on the first cycle with `trans_busy_i == 0`.
- **DONE:** `test_done_o = 1` for one cycle, then IDLE.

## Timing
- Reset (`rst_i` low, async): every output is 0, state is IDLE, the LFSR is loaded with 32'hFFFF_FFFF.
- Latency: `start_stb_i` in cycle N gives `trans_valid_o` = 1 in cycle N+1.
- Registered outputs:
  - `trans_addr_o` and `trans_type_o` are registered and stay stable while `trans_valid_o && !trans_ready_i`.
  - After a handshake the next request is presented the following cycle, with no bubble. Throughput is one request per cycle.
- `test_busy_o` is 1 from cycle N+1 through the DONE cycle inclusive.
- Zero-count start: DONE in cycle N+1, `test_done_o` pulses there, no request is issued.
- Reset mid-test: returns to IDLE immediately. No `test_done_o` pulse.

## Configuration
- Macro `MEM_CHECKER_RND_ADDR_EN`.
- **Defined:**
  - A 32-bit Galois LFSR with polynomial x^32+x^22+x^2+x+1 advances on every address advance.
  - With `addr_mode_i = 1`, address = `addr_base_i + (lfsr[ADDR_W-1:0] & addr_mask_i)`, truncated to ADDR_W bits.
  - No range check against `addr_high_i` in random mode.
- **Undefined:** no LFSR is built, `addr_mode_i` is ignored and running mode is always used.

## Test plan
- WRITE_ONLY, base 0x100, step 4, high 0x10C, count 6, ready tied 1 -> writes to 0x100, 0x104, 0x108, 0x10C, 0x100, 0x104 on consecutive cycles; `done_cnt_o` = 6; `test_done_o` pulses once after busy drops.
- WRITE_AND_CHECK, base 0x20, step 8, count 2, ready toggling 1/0 -> W 0x20, R 0x20, W 0x28, R 0x28; address and type held during ready=0; `done_cnt_o` = 4.
- READ_ONLY, count 10, `cmp_error_i` pulse after the 3rd handshake -> valid drops the next cycle; `test_error_o` = 1; DONE once `trans_busy_i` = 0; `done_cnt_o` = 3 (4 if handshake coincides with the error).
- Abort in ISSUE with `trans_busy_i` held 1 for 5 cycles -> no valid for those cycles; `test_done_o` on the 6th cycle.
- count 0 start, plus a second `start_stb_i` while busy -> DONE next cycle, no request; the second start is ignored.
- Macro defined, random mode, mask 0xFC, base 0x1000 -> every address is in 0x1000..0x10FC and 4-aligned; reset mid-test -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/test_ctrl_block.sv
// test_ctrl_block: test sequencer for the memory checker.
// Turns one CSR start command into a stream of transaction requests
// (address, type), runs the valid/ready handshake, aborts on a compare
// error or a CSR abort, waits for the transmitter to drain, and reports
// done/error/progress back to the CSRs.
// Optional feature: define MEM_CHECKER_RND_ADDR_EN to build the LFSR-based
// random address mode. Without it, addr_mode_i is ignored and
// running addresses are always used.
module test_ctrl_block #(
    parameter int ADDR_W = 31,
    parameter int CNT_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_stb_i,
    input  logic              abort_stb_i,
    input  logic [1:0]        test_mode_i,
    input  logic              addr_mode_i,
    input  logic [CNT_W-1:0]  trans_cnt_i,
    input  logic [ADDR_W-1:0] addr_base_i,
    input  logic [ADDR_W-1:0] addr_high_i,
    input  logic [ADDR_W-1:0] addr_step_i,
    input  logic [ADDR_W-1:0] addr_mask_i,
    output logic              trans_valid_o,
    output logic [ADDR_W-1:0] trans_addr_o,
    output logic              trans_type_o,
    input  logic              trans_ready_i,
    input  logic              trans_busy_i,
    input  logic              cmp_error_i,
    output logic              test_busy_o,
    output logic              test_done_o,
    output logic              test_error_o,
    output logic [CNT_W-1:0]  done_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_WR = 2'd1;
    localparam logic [1:0] MODE_WC = 2'd2;

    state_t             state_reg, state_next;
    logic [1:0]         mode_reg;
    logic [CNT_W-1:0]   slot_cnt_reg;
    logic [ADDR_W-1:0]  base_reg, high_reg, step_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic               type_reg;
    logic               error_reg;
    logic [CNT_W-1:0]   done_cnt_reg;

    logic               hs;
    logic               wc_write_phase;
    logic               slot_done;
    logic               last_slot;
    logic [ADDR_W:0]    run_sum;
    logic [ADDR_W-1:0]  run_addr;
    logic [ADDR_W-1:0]  next_addr;

    // Type of the first request of a slot: writes for WRITE_ONLY and the
    // write half of WRITE_AND_CHECK, reads otherwise (reserved mode reads).
    function automatic logic slot_type(input logic [1:0] m);
        return !((m == MODE_WR) || (m == MODE_WC));
    endfunction

    assign hs             = (state_reg == S_ISSUE) && trans_ready_i;
    assign wc_write_phase = (mode_reg == MODE_WC) && !type_reg;
    assign slot_done      = hs && !wc_write_phase;
    assign last_slot      = slot_done && (slot_cnt_reg == CNT_W'(1));

    // Running address wraps to base when it passes the high limit; the
    // extra bit keeps a carry out of ADDR_W from looking like a small value.
    assign run_sum  = {1'b0, addr_reg} + {1'b0, step_reg};
    assign run_addr = (run_sum > {1'b0, high_reg}) ? base_reg : run_sum[ADDR_W-1:0];

`ifdef MEM_CHECKER_RND_ADDR_EN
    logic               rnd_reg;
    logic [ADDR_W-1:0]  mask_reg;
    logic [31:0]        lfsr_reg;
    logic [31:0]        lfsr_next;

    // Right-shifting Galois form of x^32+x^22+x^2+x+1.
    assign lfsr_next = {1'b0, lfsr_reg[31:1]} ^ (lfsr_reg[0] ? 32'h8020_0003 : 32'h0);
    assign next_addr = rnd_reg ? (base_reg + (lfsr_next[ADDR_W-1:0] & mask_reg)) : run_addr;

    // Random-mode configuration latched at start.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rnd_reg  <= 1'b0;
            mask_reg <= '0;
        end else if ((state_reg == S_IDLE) && start_stb_i) begin
            rnd_reg  <= addr_mode_i;
            mask_reg <= addr_mask_i;
        end
    end

    // LFSR steps once per address advance so every slot sees a fresh value.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            lfsr_reg <= 32'hFFFF_FFFF;
        end else if (slot_done) begin
            lfsr_reg <= lfsr_next;
        end
    end
`else
    logic unused_rnd_cfg;
    assign unused_rnd_cfg = ^{addr_mode_i, addr_mask_i};
    assign next_addr      = run_addr;
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start only in IDLE, abort/error/last slot leave ISSUE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start_stb_i) begin
                    state_next = (trans_cnt_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_slot || abort_stb_i || cmp_error_i) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!trans_busy_i) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: latch the command at start, then advance address/type and
    // count accepted requests on each handshake.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mode_reg     <= '0;
            slot_cnt_reg <= '0;
            base_reg     <= '0;
            high_reg     <= '0;
            step_reg     <= '0;
            addr_reg     <= '0;
            type_reg     <= 1'b0;
            error_reg    <= 1'b0;
            done_cnt_reg <= '0;
        end else if ((state_reg == S_IDLE) && start_stb_i) begin
            mode_reg     <= test_mode_i;
            slot_cnt_reg <= trans_cnt_i;
            base_reg     <= addr_base_i;
            high_reg     <= addr_high_i;
            step_reg     <= addr_step_i;
            addr_reg     <= addr_base_i;
            type_reg     <= slot_type(test_mode_i);
            error_reg    <= 1'b0;
            done_cnt_reg <= '0;
        end else begin
            if (hs) begin
                if (done_cnt_reg != '1) begin
                    done_cnt_reg <= done_cnt_reg + CNT_W'(1);
                end
                if (wc_write_phase) begin
                    // Read-back of the same address follows the write.
                    type_reg <= 1'b1;
                end else begin
                    slot_cnt_reg <= slot_cnt_reg - CNT_W'(1);
                    addr_reg     <= next_addr;
                    type_reg     <= slot_type(mode_reg);
                end
            end
            if (cmp_error_i && (state_reg != S_IDLE)) begin
                error_reg <= 1'b1;
            end
        end
    end

    assign trans_valid_o = (state_reg == S_ISSUE);
    assign trans_addr_o  = addr_reg;
    assign trans_type_o  = type_reg;
    assign test_busy_o   = (state_reg != S_IDLE);
    assign test_done_o   = (state_reg == S_DONE);
    assign test_error_o  = error_reg;
    assign done_cnt_o    = done_cnt_reg;

endmodule

// File: tb/tb_test_ctrl_block.sv
// Testbench for test_ctrl_block: per-cycle vector tables for the WRITE_ONLY
// wrap and WRITE_AND_CHECK backpressure cases, hand sequences for error,
// abort/drain, zero count, mid-test reset and (with MEM_CHECKER_RND_ADDR_EN)
// random address range.
module tb_test_ctrl_block;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        start_stb_i = 1'b0;
    logic        abort_stb_i = 1'b0;
    logic [1:0]  test_mode_i = 2'd0;
    logic        addr_mode_i = 1'b0;
    logic [31:0] trans_cnt_i = 32'd0;
    logic [30:0] addr_base_i = '0;
    logic [30:0] addr_high_i = '0;
    logic [30:0] addr_step_i = '0;
    logic [30:0] addr_mask_i = '0;
    logic        trans_ready_i = 1'b0;
    logic        trans_busy_i = 1'b0;
    logic        cmp_error_i = 1'b0;
    logic        trans_valid_o;
    logic [30:0] trans_addr_o;
    logic        trans_type_o;
    logic        test_busy_o;
    logic        test_done_o;
    logic        test_error_o;
    logic [31:0] done_cnt_o;

    int checks = 0;
    int failures = 0;

    test_ctrl_block #(.ADDR_W(31), .CNT_W(32)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_stb_i   (start_stb_i),
        .abort_stb_i   (abort_stb_i),
        .test_mode_i   (test_mode_i),
        .addr_mode_i   (addr_mode_i),
        .trans_cnt_i   (trans_cnt_i),
        .addr_base_i   (addr_base_i),
        .addr_high_i   (addr_high_i),
        .addr_step_i   (addr_step_i),
        .addr_mask_i   (addr_mask_i),
        .trans_valid_o (trans_valid_o),
        .trans_addr_o  (trans_addr_o),
        .trans_type_o  (trans_type_o),
        .trans_ready_i (trans_ready_i),
        .trans_busy_i  (trans_busy_i),
        .cmp_error_i   (cmp_error_i),
        .test_busy_o   (test_busy_o),
        .test_done_o   (test_done_o),
        .test_error_o  (test_error_o),
        .done_cnt_o    (done_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        start;
        logic        abort;
        logic        ready;
        logic        busy;
        logic        cerr;
        logic        e_valid;
        logic [30:0] e_addr;
        logic        e_type;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tab_a[11];
    vec_t tab_b[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        start_stb_i = 1'b0; abort_stb_i = 1'b0; cmp_error_i = 1'b0;
        trans_ready_i = 1'b0; trans_busy_i = 1'b0; addr_mode_i = 1'b0;
        step();
        step();
        rst_i = 1'b1;
        step();
    endtask

    // Drives one row's inputs for a cycle, checks that cycle's outputs,
    // then moves past the clock edge.
    task automatic run_vec(input vec_t v, input string tag);
        start_stb_i   = v.start;
        abort_stb_i   = v.abort;
        trans_ready_i = v.ready;
        trans_busy_i  = v.busy;
        cmp_error_i   = v.cerr;
        chk({tag, ".valid"}, 32'(trans_valid_o), 32'(v.e_valid));
        chk({tag, ".busy"},  32'(test_busy_o),   32'(v.e_busy));
        chk({tag, ".done"},  32'(test_done_o),   32'(v.e_done));
        chk({tag, ".err"},   32'(test_error_o),  32'(v.e_err));
        chk({tag, ".cnt"},   done_cnt_o,         v.e_cnt);
        if (v.e_valid) begin
            chk({tag, ".addr"}, 32'(trans_addr_o), 32'(v.e_addr));
            chk({tag, ".type"}, 32'(trans_type_o), 32'(v.e_type));
        end
        $display("%s: valid=%0d addr=%0h type=%0d busy=%0d done=%0d err=%0d cnt=%0d",
                 tag, trans_valid_o, trans_addr_o, trans_type_o, test_busy_o,
                 test_done_o, test_error_o, done_cnt_o);
        step();
    endtask

    initial begin
        // start abort ready busy cerr | valid addr type busy done err cnt
        tab_a[0]  = '{1, 0, 1, 0, 0, 0, 31'h000, 0, 0, 0, 0, 0};
        tab_a[1]  = '{0, 0, 1, 1, 0, 1, 31'h100, 0, 1, 0, 0, 0};
        tab_a[2]  = '{0, 0, 1, 1, 0, 1, 31'h104, 0, 1, 0, 0, 1};
        tab_a[3]  = '{0, 0, 1, 1, 0, 1, 31'h108, 0, 1, 0, 0, 2};
        tab_a[4]  = '{0, 0, 1, 1, 0, 1, 31'h10C, 0, 1, 0, 0, 3};
        tab_a[5]  = '{0, 0, 1, 1, 0, 1, 31'h100, 0, 1, 0, 0, 4};
        tab_a[6]  = '{0, 0, 1, 1, 0, 1, 31'h104, 0, 1, 0, 0, 5};
        tab_a[7]  = '{0, 0, 1, 1, 0, 0, 31'h000, 0, 1, 0, 0, 6};
        tab_a[8]  = '{0, 0, 1, 0, 0, 0, 31'h000, 0, 1, 0, 0, 6};
        tab_a[9]  = '{0, 0, 0, 0, 0, 0, 31'h000, 0, 1, 1, 0, 6};
        tab_a[10] = '{0, 0, 0, 0, 0, 0, 31'h000, 0, 0, 0, 0, 6};

        tab_b[0]  = '{1, 0, 0, 0, 0, 0, 31'h00, 0, 0, 0, 0, 0};
        tab_b[1]  = '{0, 0, 0, 0, 0, 1, 31'h20, 0, 1, 0, 0, 0};
        tab_b[2]  = '{0, 0, 1, 0, 0, 1, 31'h20, 0, 1, 0, 0, 0};
        tab_b[3]  = '{0, 0, 0, 0, 0, 1, 31'h20, 1, 1, 0, 0, 1};
        tab_b[4]  = '{0, 0, 1, 0, 0, 1, 31'h20, 1, 1, 0, 0, 1};
        tab_b[5]  = '{0, 0, 0, 0, 0, 1, 31'h28, 0, 1, 0, 0, 2};
        tab_b[6]  = '{0, 0, 1, 0, 0, 1, 31'h28, 0, 1, 0, 0, 2};
        tab_b[7]  = '{0, 0, 0, 0, 0, 1, 31'h28, 1, 1, 0, 0, 3};
        tab_b[8]  = '{0, 0, 1, 0, 0, 1, 31'h28, 1, 1, 0, 0, 3};
        tab_b[9]  = '{0, 0, 0, 0, 0, 0, 31'h00, 0, 1, 0, 0, 4};
        tab_b[10] = '{0, 0, 0, 0, 0, 0, 31'h00, 0, 1, 1, 0, 4};
        tab_b[11] = '{0, 0, 0, 0, 0, 0, 31'h00, 0, 0, 0, 0, 4};

        // Reset state.
        #2;
        chk("reset.valid", 32'(trans_valid_o), 32'd0);
        chk("reset.busy",  32'(test_busy_o),   32'd0);
        chk("reset.cnt",   done_cnt_o,         32'd0);

        // WRITE_ONLY with address wrap, ready tied high.
        do_reset();
        test_mode_i = 2'd1; addr_base_i = 31'h100; addr_step_i = 31'd4;
        addr_high_i = 31'h10C; trans_cnt_i = 32'd6;
        for (int i = 0; i < 11; i++) run_vec(tab_a[i], $sformatf("wo[%0d]", i));

        // WRITE_AND_CHECK with ready toggling.
        do_reset();
        test_mode_i = 2'd2; addr_base_i = 31'h20; addr_step_i = 31'd8;
        addr_high_i = 31'hFF; trans_cnt_i = 32'd2;
        for (int i = 0; i < 12; i++) run_vec(tab_b[i], $sformatf("wc[%0d]", i));

        // READ_ONLY, compare error after the 3rd handshake (ready low then).
        do_reset();
        test_mode_i = 2'd0; addr_base_i = 31'h0; addr_step_i = 31'd1;
        addr_high_i = 31'h7FFF_FFFF; trans_cnt_i = 32'd10;
        start_stb_i = 1'b1; trans_ready_i = 1'b1; trans_busy_i = 1'b1;
        step();
        start_stb_i = 1'b0;
        chk("err.valid_n1", 32'(trans_valid_o), 32'd1);
        chk("err.type_rd",  32'(trans_type_o),  32'd1);
        chk("err.busy_n1",  32'(test_busy_o),   32'd1);
        step(); step(); step();
        chk("err.cnt3",  done_cnt_o,            32'd3);
        chk("err.addr3", 32'(trans_addr_o),     32'd3);
        trans_ready_i = 1'b0; cmp_error_i = 1'b1;
        step();
        cmp_error_i = 1'b0;
        chk("err.valid_drop", 32'(trans_valid_o), 32'd0);
        chk("err.flag",       32'(test_error_o),  32'd1);
        chk("err.cnt_hold",   done_cnt_o,         32'd3);
        step();
        chk("err.no_done_busy", 32'(test_done_o), 32'd0);
        trans_busy_i = 1'b0;
        step();
        chk("err.done", 32'(test_done_o), 32'd1);
        step();
        chk("err.idle",   32'(test_busy_o),  32'd0);
        chk("err.sticky", 32'(test_error_o), 32'd1);
        $display("error seq: err=%0d cnt=%0d", test_error_o, done_cnt_o);

        // Abort in ISSUE, busy held for 5 cycles from the abort cycle;
        // a start while issuing must be ignored.
        do_reset();
        test_mode_i = 2'd1; addr_base_i = 31'h0; addr_step_i = 31'd4;
        addr_high_i = 31'hFFFF; trans_cnt_i = 32'd10;
        start_stb_i = 1'b1; trans_ready_i = 1'b1;
        step();
        start_stb_i = 1'b0;
        step();
        start_stb_i = 1'b1; trans_cnt_i = 32'd0;
        step();
        start_stb_i = 1'b0;
        abort_stb_i = 1'b1; trans_busy_i = 1'b1;
        step();
        abort_stb_i = 1'b0;
        for (int k = 1; k < 5; k++) begin
            chk($sformatf("abort.valid%0d", k), 32'(trans_valid_o), 32'd0);
            chk($sformatf("abort.done%0d", k),  32'(test_done_o),   32'd0);
            step();
        end
        trans_busy_i = 1'b0;
        chk("abort.done5", 32'(test_done_o), 32'd0);
        step();
        chk("abort.done6", 32'(test_done_o),  32'd1);
        chk("abort.cnt",   done_cnt_o,        32'd3);
        chk("abort.noerr", 32'(test_error_o), 32'd0);
        step();
        chk("abort.idle", 32'(test_busy_o), 32'd0);
        $display("abort seq: cnt=%0d", done_cnt_o);

        // Zero-count start, plus a second start while busy in DONE.
        do_reset();
        trans_cnt_i = 32'd0; start_stb_i = 1'b1;
        step();
        chk("zero.done",  32'(test_done_o),   32'd1);
        chk("zero.busy",  32'(test_busy_o),   32'd1);
        chk("zero.valid", 32'(trans_valid_o), 32'd0);
        step();
        start_stb_i = 1'b0;
        chk("zero.idle",   32'(test_busy_o), 32'd0);
        chk("zero.nodone", 32'(test_done_o), 32'd0);
        step();
        chk("zero.ignored", 32'(test_busy_o), 32'd0);
        $display("zero seq: busy=%0d done=%0d", test_busy_o, test_done_o);

        // Reset in the middle of ISSUE clears outputs without a clock edge.
        do_reset();
        test_mode_i = 2'd1; addr_base_i = 31'h40; addr_step_i = 31'd4;
        addr_high_i = 31'hFFF; trans_cnt_i = 32'd10;
        start_stb_i = 1'b1; trans_ready_i = 1'b1;
        step();
        start_stb_i = 1'b0;
        step(); step();
        chk("mrst.pre_valid", 32'(trans_valid_o), 32'd1);
        chk("mrst.pre_addr",  32'(trans_addr_o),  32'h48);
        #2 rst_i = 1'b0;
        #1;
        chk("mrst.valid", 32'(trans_valid_o), 32'd0);
        chk("mrst.addr",  32'(trans_addr_o),  32'd0);
        chk("mrst.busy",  32'(test_busy_o),   32'd0);
        chk("mrst.cnt",   done_cnt_o,         32'd0);
        step();
        rst_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("mrst.nodone%0d", k), 32'(test_done_o), 32'd0);
        end
        $display("midreset seq: busy=%0d done=%0d", test_busy_o, test_done_o);

`ifdef MEM_CHECKER_RND_ADDR_EN
        // Random mode: every address within base..base+mask, 4-aligned.
        begin
            int hs_seen;
            hs_seen = 0;
            do_reset();
            test_mode_i = 2'd0; addr_mode_i = 1'b1; addr_base_i = 31'h1000;
            addr_mask_i = 31'hFC; addr_step_i = 31'd4; addr_high_i = 31'h1000;
            trans_cnt_i = 32'd20; trans_ready_i = 1'b1;
            start_stb_i = 1'b1;
            step();
            start_stb_i = 1'b0;
            for (int k = 0; k < 40 && trans_valid_o; k++) begin
                chk($sformatf("rnd.addr%0d", k),
                    32'((trans_addr_o >= 31'h1000) && (trans_addr_o <= 31'h10FC) &&
                        (trans_addr_o[1:0] == 2'b00)), 32'd1);
                $display("rnd[%0d]: addr=%0h", k, trans_addr_o);
                hs_seen++;
                step();
            end
            chk("rnd.count", 32'(hs_seen), 32'd20);
            chk("rnd.cnt",   done_cnt_o,   32'd20);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
